// File: rtl/scan_chain_loader.sv
// Serialises valid/ready configuration words into a scan chain, image LSB first.
// Define SCAN_CAPTURE_EN to capture the chain tail (so) as a readback of the old contents.
module scan_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              so,
  output logic              se,
  output logic              si,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] cap_data,
  output logic              cap_valid
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int BW        = $clog2(WORD_W + 1);
  localparam int WCW       = $clog2(NWORDS + 1);

  localparam logic [BW-1:0]  FULL_CNT  = BW'(WORD_W);
  localparam logic [BW-1:0]  LAST_CNT  = BW'(LAST_BITS);
  localparam logic [BW-1:0]  ONE_BIT   = BW'(1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [WCW-1:0] ALL_WORDS = WCW'(NWORDS);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;   // bits of the current word still to drive, including this cycle
  logic [WCW-1:0]    word_cnt;  // words accepted so far in this load

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      se        <= 1'b0;
      si        <= 1'b0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            word_cnt  <= '0;
            bit_cnt   <= '0;
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            state     <= SHIFT;
            cfg_ready <= 1'b0;
            se        <= 1'b1;
            si        <= cfg_data[0];
            shreg     <= cfg_data >> 1;
            bit_cnt   <= (word_cnt == LAST_WORD) ? LAST_CNT : FULL_CNT;
            word_cnt  <= word_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == ONE_BIT) begin
            // Last bit of this word is on si now; drop se so the chain holds.
            se      <= 1'b0;
            si      <= 1'b0;
            bit_cnt <= '0;
            if (word_cnt == ALL_WORDS) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              cfg_ready <= 1'b1;
            end
          end else begin
            si      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_CAPTURE_EN
  logic [WORD_W-1:0] cap_acc;
  logic [BW-1:0]     cap_pos;

  // so shows the old chain tail during each SHIFT cycle, so it lines up bit-for-bit with si.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_acc   <= '0;
      cap_pos   <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_valid <= 1'b0;
      if (state == FETCH && cfg_valid) begin
        cap_acc <= '0;
        cap_pos <= '0;
      end else if (state == SHIFT) begin
        if (bit_cnt == ONE_BIT) begin
          cap_data  <= cap_acc | (WORD_W'(so) << cap_pos);
          cap_valid <= 1'b1;
        end else begin
          cap_acc <= cap_acc | (WORD_W'(so) << cap_pos);
          cap_pos <= cap_pos + 1'b1;
        end
      end
    end
  end
`else
  logic unused_so;
  assign unused_so = so;
  assign cap_data  = '0;
  assign cap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader: a bit-queue model of the expected serial stream
// plus a behavioural scan chain, checked every cycle, with literal image checks.
module tb_scan_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = 3;
  localparam logic [23:0] WORDS = 24'hF93CA5;

  logic clk = 1'b0;
  logic reset, start, cfg_valid, cfg_ready, so, se, si, busy, done, cap_valid;
  logic [WW-1:0] cfg_data, cap_data;

  always #5 clk = ~clk;

  scan_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .so(so), .se(se), .si(si), .busy(busy), .done(done),
    .cap_data(cap_data), .cap_valid(cap_valid)
  );

  // Behavioural chain: si enters at the top, q[0] is the tail.
  logic [CL-1:0] q, preload_val;
  logic preload_en;
  always @(posedge clk) begin
    if (preload_en) q <= preload_val;
    else if (se) q <= {si, q[CL-1:1]};
  end
  assign so = q[0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word contributes its bits (LSB first) to the expected stream.
  bit            exp_q[$];
  int            bursts[$];
  logic [WW-1:0] caps[$];
  logic [CL-1:0] model_img;
  int wi, run, cyc, t0, last_len, done_cnt, words_last, nb;
  bit in_load, prev_done;

  initial begin
    wi = 0; run = 0; cyc = 0; t0 = 0; last_len = 0; done_cnt = 0; words_last = 0; nb = 0;
    in_load = 0; prev_done = 0; model_img = '0;
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      wi = 0; run = 0; in_load = 0; prev_done = 0;
    end else begin
      if (!se) check("si_low_when_idle", si, 0);
      if (se) begin
        check("se_implies_busy", busy, 1);
        check("bits_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("si_bit", si, exp_q.pop_front());
        run++;
      end else if (run > 0) begin
        bursts.push_back(run);
        run = 0;
      end
      if (cfg_ready) begin
        check("ready_no_se", se, 0);
        check("ready_busy", busy, 1);
        if (!in_load) begin in_load = 1; t0 = cyc; end
      end
      if (prev_done) begin
        check("post_done_busy", busy, 0);
        check("post_done_done", done, 0);
      end
      if (done) begin
        check("done_bits_left", exp_q.size(), 0);
        check("done_words", wi, NW);
        check("done_busy", busy, 1);
        last_len = cyc - t0;
        words_last = wi;
        in_load = 0;
        wi = 0;
        done_cnt++;
      end
      prev_done = done;
`ifdef SCAN_CAPTURE_EN
      if (cap_valid) caps.push_back(cap_data);
`else
      check("cap_valid_zero", cap_valid, 0);
      check("cap_data_zero", cap_data, 0);
`endif
      if (cfg_valid && cfg_ready) begin
        nb = (wi == NW-1) ? CL - (NW-1)*WW : WW;
        if (wi == 0) begin model_img = '0; bursts.delete(); caps.delete(); end
        for (int b = 0; b < nb; b++) begin
          exp_q.push_back(cfg_data[b]);
          model_img[wi*WW + b] = cfg_data[b];
        end
        wi++;
      end
    end
  end

  task automatic preload(input logic [CL-1:0] v);
    preload_en = 1; preload_val = v;
    @(posedge clk); #1;
    preload_en = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic feed(input logic [23:0] words, input int gap_word, input int gap_len);
    int i, g, guard;
    bit hs;
    i = 0; g = 0; guard = 0;
    while (i < NW && guard < 200 && !reset) begin
      if (i == gap_word && g < gap_len) cfg_valid = 0;
      else begin cfg_valid = 1; cfg_data = words[i*WW +: WW]; end
      @(negedge clk);
      hs = cfg_valid && cfg_ready;
      if (!cfg_valid && cfg_ready) g++;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    cfg_valid = 0;
    if (!reset) check("feed_words", i, NW);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    check("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input logic [23:0] words, input int gap_word, input int gap_len);
    pulse_start();
    feed(words, gap_word, gap_len);
    wait_done();
  endtask

  initial begin
    int d0, n, k;
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, n, k;
    reset = 1; start = 0; cfg_valid = 0; cfg_data = '0; preload_en = 1; preload_val = '0;
    repeat (2) @(posedge clk);
    #1 preload_en = 0;
    @(negedge clk);
    check("rst_se", se, 0);        check("rst_si", si, 0);
    check("rst_ready", cfg_ready, 0); check("rst_busy", busy, 0);
    check("rst_done", done, 0);    check("rst_cap_valid", cap_valid, 0);
    check("rst_cap_data", cap_data, 0);
    @(posedge clk); #1 reset = 0;

    // Plain load, cfg_valid held high
    preload(20'h5A5A5);
    d0 = done_cnt;
    run_load(WORDS, -1, 0);
    check("t1_image_literal", q, 20'h93CA5);
    check("t1_image_model", q, model_img);
    check("t1_bursts", bursts.size(), 3);
    if (bursts.size() == 3) begin
      check("t1_burst0", bursts[0], 8);
      check("t1_burst1", bursts[1], 8);
      check("t1_burst2", bursts[2], 4);
    end
    check("t1_len", last_len, CL + NW);
    check("t1_done_once", done_cnt, d0 + 1);
    check("t1_busy_after", busy, 0);

    // Back-pressure gap of 5 FETCH cycles before word 1
    preload(20'h5A5A5);
    run_load(WORDS, 1, 5);
    check("t2_image_literal", q, 20'h93CA5);
    check("t2_len", last_len, CL + NW + 5);

    // Reset after 10 shifted bits
    preload(20'h00000);
    d0 = done_cnt;
    pulse_start();
    fork feed(WORDS, -1, 0); join_none
    n = 0; k = 0;
    while (n < 10 && k < 100) begin
      @(negedge clk);
      if (se) n++;
      k++;
    end
    check("t3_shift10", n, 10);
    reset = 1;
    @(posedge clk); #1;
    check("t3_se", se, 0); check("t3_busy", busy, 0);
    check("t3_ready", cfg_ready, 0); check("t3_done", done, 0);
    check("t3_partial_chain", q, 20'h29400);
    @(posedge clk); #1 reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_no_done", done_cnt, d0);
    run_load(WORDS, -1, 0);
    check("t3_reload_image", q, 20'h93CA5);
    check("t3_one_done", done_cnt, d0 + 1);

    // start re-pulsed during SHIFT and during DONE
    preload(20'h00000);
    d0 = done_cnt;
    pulse_start();
    fork feed(WORDS, -1, 0); join_none
    k = 0;
    while (k < 100) begin @(negedge clk); if (se) break; k++; end
    check("t4_se_seen", se, 1);
    @(posedge clk); #1;
    pulse_start();
    k = 0;
    while (k < 100) begin @(negedge clk); if (done) break; k++; end
    check("t4_done_seen", done, 1);
    start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_no_restart", cfg_ready, 0);
    end
    check("t4_one_done", done_cnt, d0 + 1);
    check("t4_words", words_last, NW);
    check("t4_image", q, 20'h93CA5);
    @(posedge clk); #1;

    // cfg_valid while IDLE without start
    cfg_valid = 1; cfg_data = 8'h77;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_ready_low", cfg_ready, 0);
      check("t5_se_low", se, 0);
    end
    check("t5_no_word", wi, 0);
    @(posedge clk); #1 cfg_valid = 0;

`ifdef SCAN_CAPTURE_EN
    preload(20'hFFFFF);
    run_load(24'h000000, -1, 0);
    check("t6_caps", caps.size(), 3);
    if (caps.size() == 3) begin
      check("t6_cap0", caps[0], 8'hFF);
      check("t6_cap1", caps[1], 8'hFF);
      check("t6_cap2", caps[2], 8'h0F);
    end
    check("t6_image", q, 20'h00000);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Upstream controller for the configuration scan chain: accepts configuration words over a valid/ready handshake and serialises them into the chain's si/se pins.
- The chain shifts only while se=1; after exactly CHAIN_LEN shift cycles, chain flop q[k] holds bit k of the assembled configuration image.
- Sits between the top-level config port (or testbench) and the chain head.
- Reports busy/done so the array controller knows when configuration is stable.

Parameters:
- CHAIN_LEN, 64, total number of scan flops in the downstream chain (>=1).
- WORD_W, 16, width of one input configuration word (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a full chain load; honoured only in IDLE
- cfg_data  input  WORD_W  configuration word; word j carries image bits [j*WORD_W +: WORD_W]
- cfg_valid  input  1  cfg_data valid
- cfg_ready  output  1  loader accepts a word this cycle
- so  input  1  chain tail output; used only with SCAN_CAPTURE_EN
- se  output  1  scan enable to chain head; high exactly on cycles a bit shifts
- si  output  1  serial data to chain head
- busy  output  1  high from the cycle after start is accepted until the cycle after DONE
- done  output  1  one-cycle pulse; load complete
- cap_data  output  WORD_W  captured old chain contents (feature only, else 0)
- cap_valid  output  1  cap_data valid pulse (feature only, else 0)

Behaviour:
- NWORDS = ceil(CHAIN_LEN/WORD_W). For the last word, only the low CHAIN_LEN-(NWORDS-1)*WORD_W bits are shifted; its upper bits are discarded.
- Bit order: image LSB first. Within each word, bit 0 is shifted first. The first bit shifted ends at q[0]; the last ends at q[CHAIN_LEN-1].
- FSM states IDLE, FETCH, SHIFT, DONE. All outputs come directly from registers or the state register; no combinational path from inputs to outputs.
- IDLE: start=1 -> FETCH; word counter and bit counter cleared.
- FETCH: cfg_ready=1. When cfg_valid&cfg_ready at an edge, load cfg_data into the shift register and load the bits-this-word count -> SHIFT.
- SHIFT: se=1 and si=shreg[0] every cycle; shreg shifts right by 1 each cycle. When the word's last bit is driven: more words remaining -> FETCH, else -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Minimum one-cycle bubble (se=0) between words. Full load with cfg_valid held high = CHAIN_LEN + NWORDS cycles from FETCH entry to DONE entry.
- se=0 in every state but SHIFT, so chain contents hold during back-pressure gaps.
- si=0 whenever se=0.
- start while busy or in DONE: ignored, no effect.
- cfg_valid outside FETCH: ignored; word not consumed (cfg_ready=0).
- Reset values: state IDLE; se, si, cfg_ready, busy, done, cap_valid = 0; cap_data = 0; all counters = 0.
- Reset mid-load: next cycle is IDLE with all outputs at reset values, no done pulse. The chain keeps its partial contents and the next start performs a full reload.
- Counters: bit counter width $clog2(WORD_W+1); word counter width $clog2(NWORDS+1). No wrap: terminal counts are compared exactly.

Optional Feature:
- Macro SCAN_CAPTURE_EN.
- Defined: on each SHIFT cycle the loader samples so into a capture register, LSB first, mirroring si ordering. After the last bit of each word it drives cap_data with the assembled bits and pulses cap_valid for one cycle; on the last word, unused upper bits are 0. No back-pressure on the capture output. The result is a non-destructive readback of the previous chain contents during a load.
- Not defined: so is unused; cap_data=0 and cap_valid=0 permanently; no capture logic is synthesised.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0xF9 with cfg_valid held high, start pulsed -> se high for exactly 20 cycles in 3 bursts of 8/8/4; model chain q=0x93CA5; done single pulse; busy falls the cycle after done.
- Same load with cfg_valid low for 5 cycles before word 1 -> se=0 and chain frozen during the gap; final q=0x93CA5; total cycles +5.
- reset asserted after 10 shifted bits -> next cycle se=0, busy=0, cfg_ready=0, no done; a fresh start then loads 0x93CA5 correctly.
- start re-pulsed during SHIFT and during DONE -> ignored; exactly one done; word count consumed = 3.
- cfg_valid high while IDLE with no start -> cfg_ready stays 0; no word consumed; se stays 0.
- SCAN_CAPTURE_EN, chain preloaded 0xFFFFF, load 0x00000 -> cap_valid pulses 3 times with cap_data 0xFF, 0xFF, 0x0F; final q=0x00000.
